fe_mul_arbiter: RTL and testbench

Sequences and shares the single field-element multiplier (`fe_mulx`) between the two curve-arithmetic requesters in the EPU: port 0 (double-scalar-mult engine) and port 1 (second requester). It latches one request's operands, issues them to the multiplier, waits for completion, and returns the product to the owning requester. Round-robin arbitration keeps either requester from starving the other. A watchdog flags a multiplier that never completes.

---
 rtl/fe_mul_arbiter_if.sv | 43 ++++
 rtl/fe_mul_arbiter.sv | 138 +++++++++++++
 tb/tb_fe_mul_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fe_mul_arbiter_if.sv
// Requester and multiplier bus of the field-element multiplier arbiter.
// The slave modport is the arbiter; the master modport is its environment.
interface fe_mul_arbiter_if #(
    parameter int unsigned WIDTH = 320
);
    logic             req0_valid;
    logic [WIDTH-1:0] req0_op_a;
    logic [WIDTH-1:0] req0_op_b;
    logic             req0_ready;
    logic             req0_done;
    logic [WIDTH-1:0] req0_res;

    logic             req1_valid;
    logic [WIDTH-1:0] req1_op_a;
    logic [WIDTH-1:0] req1_op_b;
    logic             req1_ready;
    logic             req1_done;
    logic [WIDTH-1:0] req1_res;

    logic [WIDTH-1:0] mul_op_a;
    logic [WIDTH-1:0] mul_op_b;
    logic             mul_valid;
    logic [WIDTH-1:0] mul_res;
    logic             mul_done;

    modport slave (
        input  req0_valid, req0_op_a, req0_op_b,
        output req0_ready, req0_done, req0_res,
        input  req1_valid, req1_op_a, req1_op_b,
        output req1_ready, req1_done, req1_res,
        output mul_op_a, mul_op_b, mul_valid,
        input  mul_res, mul_done
    );

    modport master (
        output req0_valid, req0_op_a, req0_op_b,
        input  req0_ready, req0_done, req0_res,
        output req1_valid, req1_op_a, req1_op_b,
        input  req1_ready, req1_done, req1_res,
        input  mul_op_a, mul_op_b, mul_valid,
        output mul_res, mul_done
    );
endinterface

// File: rtl/fe_mul_arbiter.sv
// Shares one field-element multiplier between two requesters with round-robin
// arbitration, a completion watchdog and a sticky fault flag.
module fe_mul_arbiter #(
    parameter int unsigned WIDTH   = 320,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic            modclk,
    input  logic            resetn,
    fe_mul_arbiter_if.slave bus,
    output logic            busy,
    output logic            err
);
    localparam int unsigned      CNT_W   = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam bit               WD_EN   = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RET  = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_last_grant;
    logic             r_owner;
    logic [1:0]       r_ready;
    logic [1:0]       r_done;
    logic [WIDTH-1:0] r_res0;
    logic [WIDTH-1:0] r_res1;
    logic [WIDTH-1:0] r_op_a;
    logic [WIDTH-1:0] r_op_b;
    logic             r_mul_valid;
    logic             r_busy;
    logic             r_err;
    logic [CNT_W-1:0] r_cnt;

    logic             w_req_any;
    logic             w_pick;
    logic             w_expire;
    logic             w_completion;
    logic [WIDTH-1:0] w_sel_a;
    logic [WIDTH-1:0] w_sel_b;

    // On a tie the port that did not win last time is granted.
    assign w_req_any    = bus.req0_valid | bus.req1_valid;
    assign w_pick       = (bus.req0_valid & bus.req1_valid) ? ~r_last_grant : bus.req1_valid;
    assign w_sel_a      = w_pick ? bus.req1_op_a : bus.req0_op_a;
    assign w_sel_b      = w_pick ? bus.req1_op_b : bus.req0_op_b;
    assign w_expire     = WD_EN && (r_cnt >= CNT_LIM);
    // A done in the same cycle as the start pulse violates the multiplier contract.
    assign w_completion = bus.mul_done & ~r_mul_valid;

    always_ff @(posedge modclk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_owner      <= 1'b0;
            r_ready      <= 2'b00;
            r_done       <= 2'b00;
            r_res0       <= '0;
            r_res1       <= '0;
            r_op_a       <= '0;
            r_op_b       <= '0;
            r_mul_valid  <= 1'b0;
            r_busy       <= 1'b0;
            r_err        <= 1'b0;
            r_cnt        <= '0;
        end else begin
            r_ready     <= 2'b00;
            r_done      <= 2'b00;
            r_mul_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.mul_done) begin
                        r_err <= 1'b1;
                    end
                    if (w_req_any) begin
                        r_op_a          <= w_sel_a;
                        r_op_b          <= w_sel_b;
                        r_ready[w_pick] <= 1'b1;
                        r_mul_valid     <= 1'b1;
                        r_owner         <= w_pick;
                        r_last_grant    <= w_pick;
                        r_cnt           <= '0;
                        r_busy          <= 1'b1;
                        r_state         <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Completion takes priority over a watchdog expiry on the same edge.
                    if (w_completion) begin
                        if (r_owner) r_res1 <= bus.mul_res;
                        else         r_res0 <= bus.mul_res;
                        r_done[r_owner] <= 1'b1;
                        r_state         <= S_RET;
                    end else if (w_expire) begin
                        if (r_owner) r_res1 <= '0;
                        else         r_res0 <= '0;
                        r_done[r_owner] <= 1'b1;
                        r_err           <= 1'b1;
                        r_state         <= S_RET;
                    end else begin
                        if (bus.mul_done) begin
                            r_err <= 1'b1;
                        end
                        if (r_cnt != CNT_MAX) begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                S_RET: begin
                    if (bus.mul_done) begin
                        r_err <= 1'b1;
                    end
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req0_ready = r_ready[0];
    assign bus.req1_ready = r_ready[1];
    assign bus.req0_done  = r_done[0];
    assign bus.req1_done  = r_done[1];
    assign bus.req0_res   = r_res0;
    assign bus.req1_res   = r_res1;
    assign bus.mul_op_a   = r_op_a;
    assign bus.mul_op_b   = r_op_b;
    assign bus.mul_valid  = r_mul_valid;
    assign busy           = r_busy;
    assign err            = r_err;
endmodule

// File: tb/tb_fe_mul_arbiter.sv
// Scoreboard bench for fe_mul_arbiter: requesters push expected products, a
// multiplier model answers with random latency, a monitor checks every done.
module tb_fe_mul_arbiter;
    localparam int unsigned W  = 64;
    localparam int unsigned TO = 8;

    logic modclk = 1'b0;
    logic resetn = 1'b0;
    logic busy;
    logic err;

    fe_mul_arbiter_if #(.WIDTH(W)) bus ();

    fe_mul_arbiter #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .modclk (modclk),
        .resetn (resetn),
        .bus    (bus),
        .busy   (busy),
        .err    (err)
    );

    always #5 modclk = ~modclk;

    logic         v   [2];
    logic [W-1:0] opa [2];
    logic [W-1:0] opb [2];

    assign bus.req0_valid = v[0];
    assign bus.req0_op_a  = opa[0];
    assign bus.req0_op_b  = opb[0];
    assign bus.req1_valid = v[1];
    assign bus.req1_op_a  = opa[1];
    assign bus.req1_op_b  = opb[1];

    int n_checks = 0;
    int n_errors = 0;

    logic [W-1:0] exp0 [$];
    logic [W-1:0] exp1 [$];
    int           gexp [$];

    int mul_hang  = 0;
    int fixed_lat = 0;
    int spur_cnt  = 0;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] want);
        n_checks++;
        if (act !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, want, $time);
        end
    endtask

    function automatic logic rdy(input int p);
        return (p == 0) ? bus.req0_ready : bus.req1_ready;
    endfunction

    function automatic logic dn(input int p);
        return (p == 0) ? bus.req0_done : bus.req1_done;
    endfunction

    function automatic logic [W-1:0] rnd();
        return {$urandom, $urandom};
    endfunction

    // Multiplier model: product after a latency of 1..TO cycles, or never when hung.
    int           m_cnt  = 0;
    int           m_seen = 0;
    logic [W-1:0] m_a    = '0;
    logic [W-1:0] m_b    = '0;
    bit           m_fire;
    bit           m_spur;
    initial begin
        bus.mul_done = 1'b0;
        bus.mul_res  = '0;
        forever begin
            @(negedge modclk);
            m_fire = 1'b0;
            m_spur = 1'b0;
            if (!resetn) begin
                m_cnt = 0;
            end else if (bus.mul_valid) begin
                m_a   = bus.mul_op_a;
                m_b   = bus.mul_op_b;
                m_cnt = (mul_hang != 0) ? 0 :
                        (fixed_lat != 0) ? fixed_lat : int'($urandom_range(1, TO));
            end
            if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) m_fire = 1'b1;
            end
            if (spur_cnt != m_seen) begin
                m_seen = spur_cnt;
                m_fire = 1'b1;
                m_spur = 1'b1;
            end
            @(posedge modclk);
            #1;
            bus.mul_done = m_fire;
            if (m_fire) bus.mul_res = m_spur ? rnd() : m_a * m_b;
        end
    end

    // Monitor: compares every done against the scoreboard and every grant against the grant queue.
    logic [W-1:0] mon_e;
    int           mon_g;
    initial begin
        forever begin
            @(negedge modclk);
            if (resetn) begin
                if (bus.req0_done && bus.req1_done) begin
                    n_checks++; n_errors++;
                    $display("FAIL both_done: got 1 1 expected at most one at %0t", $time);
                end
                if (bus.req0_done) begin
                    if (exp0.size() == 0) begin
                        n_checks++; n_errors++;
                        $display("FAIL unexpected_done0: got done res %0h expected no done at %0t", bus.req0_res, $time);
                    end else begin
                        mon_e = exp0.pop_front();
                        chk("res0", bus.req0_res, mon_e);
                    end
                end
                if (bus.req1_done) begin
                    if (exp1.size() == 0) begin
                        n_checks++; n_errors++;
                        $display("FAIL unexpected_done1: got done res %0h expected no done at %0t", bus.req1_res, $time);
                    end else begin
                        mon_e = exp1.pop_front();
                        chk("res1", bus.req1_res, mon_e);
                    end
                end
                if (bus.mul_valid !== (bus.req0_ready ^ bus.req1_ready)) begin
                    n_checks++; n_errors++;
                    $display("FAIL grant_pulse: got mul_valid %0b ready %0b%0b expected exactly one ready with mul_valid",
                             bus.mul_valid, bus.req1_ready, bus.req0_ready);
                end
                if ((bus.req0_ready && !v[0]) || (bus.req1_ready && !v[1])) begin
                    n_checks++; n_errors++;
                    $display("FAIL ready_no_req: got ready %0b%0b expected ready only for a pending port",
                             bus.req1_ready, bus.req0_ready);
                end
                if ((bus.req0_ready || bus.req1_ready) && gexp.size() != 0) begin
                    mon_g = gexp.pop_front();
                    chk("grant_port", W'(bus.req1_ready), W'(mon_g));
                end
            end
        end
    end

    task automatic do_reset();
        resetn = 1'b0;
        exp0.delete();
        exp1.delete();
        gexp.delete();
        repeat (2) @(posedge modclk);
        #1 resetn = 1'b1;
    endtask

    // Issue one request with strict cycle checks; caller sits just after a rising edge.
    task automatic req_timed(input int p, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [W-1:0] e, input int done_cyc);
        v[p] = 1'b1; opa[p] = a; opb[p] = b;
        if (p == 0) exp0.push_back(e); else exp1.push_back(e);
        @(negedge modclk);
        chk("ready_c0", W'(rdy(p)), W'(0));
        @(negedge modclk);
        chk("ready_c1", W'(rdy(p)), W'(1));
        chk("mul_valid_c1", W'(bus.mul_valid), W'(1));
        chk("mul_op_a_c1", bus.mul_op_a, a);
        chk("mul_op_b_c1", bus.mul_op_b, b);
        chk("busy_c1", W'(busy), W'(1));
        @(posedge modclk);
        #1 v[p] = 1'b0;
        for (int c = 2; c <= done_cyc + 1; c++) begin
            @(negedge modclk);
            chk($sformatf("done_c%0d", c), W'(dn(p)), W'(c == done_cyc));
            chk($sformatf("busy_c%0d", c), W'(busy), W'(c <= done_cyc));
        end
        @(posedge modclk);
        #1;
    endtask

    // Issue one request and wait (bounded) for its ready; leaves valid low one cycle after ready.
    task automatic req_issue(input int p, input logic [W-1:0] a, input logic [W-1:0] b);
        bit got;
        got = 1'b0;
        v[p] = 1'b1; opa[p] = a; opb[p] = b;
        if (p == 0) exp0.push_back(a * b); else exp1.push_back(a * b);
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge modclk);
            if (rdy(p)) got = 1'b1;
        end
        if (!got) begin
            n_checks++; n_errors++;
            $display("FAIL ready_timeout%0d: got no ready expected ready within 300 cycles", p);
        end
        @(posedge modclk);
        #1 v[p] = 1'b0;
    endtask

    task automatic port_random(input int p, input int n);
        int gap;
        for (int k = 0; k < n; k++) begin
            gap = int'($urandom_range(0, 4));
            for (int g = 0; g < gap; g++) begin
                @(posedge modclk);
                #1;
            end
            req_issue(p, rnd(), rnd());
        end
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge modclk);
        #1;
    endtask

    initial begin
        v[0] = 1'b0; v[1] = 1'b0;
        opa[0] = '0; opa[1] = '0; opb[0] = '0; opb[1] = '0;
        do_reset();

        // Reset state
        @(negedge modclk);
        chk("rst_busy", W'(busy), W'(0));
        chk("rst_err", W'(err), W'(0));
        chk("rst_res0", bus.req0_res, '0);
        chk("rst_res1", bus.req1_res, '0);
        chk("rst_mul_op_a", bus.mul_op_a, '0);
        chk("rst_mul_valid", W'(bus.mul_valid), W'(0));
        chk("rst_ready0", W'(bus.req0_ready), W'(0));
        chk("rst_done0", W'(bus.req0_done), W'(0));
        settle(1);

        // Spurious done in IDLE
        spur_cnt++;
        settle(3);
        chk("spur_err", W'(err), W'(1));
        chk("spur_busy", W'(busy), W'(0));
        do_reset();
        chk("spur_err_cleared", W'(err), W'(0));

        // Single request: 3*5 with latency 4, done at cycle 6
        fixed_lat = 4;
        req_timed(0, W'(3), W'(5), W'(15), 6);
        fixed_lat = 0;
        chk("single_err", W'(err), W'(0));

        // Tie after reset: port 0 first, then port 1
        do_reset();
        gexp.push_back(0); gexp.push_back(1);
        fork
            req_issue(0, rnd(), rnd());
            req_issue(1, rnd(), rnd());
        join
        settle(14);
        chk("tie_grants_used", W'(gexp.size()), W'(0));

        // Fairness: both hold valid for 6 operations, strict alternation
        for (int i = 0; i < 6; i++) gexp.push_back(i % 2);
        fork
            for (int k = 0; k < 3; k++) req_issue(0, rnd(), rnd());
            for (int k = 0; k < 3; k++) req_issue(1, rnd(), rnd());
        join
        settle(14);
        chk("fair_grants_used", W'(gexp.size()), W'(0));

        // Random traffic with latencies up to the watchdog limit
        fork
            port_random(0, 10);
            port_random(1, 10);
        join
        settle(14);
        chk("rand_err", W'(err), W'(0));
        chk("rand_exp0_drained", W'(exp0.size()), W'(0));
        chk("rand_exp1_drained", W'(exp1.size()), W'(0));

        // Watchdog: multiplier never answers, done at cycle 2+TO with zero result
        mul_hang = 1;
        req_timed(0, rnd(), rnd(), '0, 2 + TO);
        mul_hang = 0;
        chk("to_err", W'(err), W'(1));
        chk("to_res0", bus.req0_res, '0);
        spur_cnt++;
        settle(3);
        chk("late_done_err", W'(err), W'(1));
        chk("late_done_res0", bus.req0_res, '0);
        chk("late_done_busy", W'(busy), W'(0));

        // Asynchronous reset while waiting for the multiplier
        fixed_lat = TO;
        v[0] = 1'b1; opa[0] = rnd() | W'(1); opb[0] = rnd();
        @(negedge modclk);
        @(negedge modclk);
        chk("mid_ready", W'(bus.req0_ready), W'(1));
        @(posedge modclk);
        #1 v[0] = 1'b0;
        repeat (2) @(negedge modclk);
        #2 resetn = 1'b0;
        #1;
        chk("mid_busy", W'(busy), W'(0));
        chk("mid_err", W'(err), W'(0));
        chk("mid_mul_op_a", bus.mul_op_a, '0);
        chk("mid_res1", bus.req1_res, '0);
        exp0.delete(); exp1.delete(); gexp.delete();
        repeat (2) @(posedge modclk);
        #1 resetn = 1'b1;
        fixed_lat = 0;
        settle(1);
        spur_cnt++;
        settle(3);
        chk("post_rst_spur_err", W'(err), W'(1));
        gexp.push_back(0); gexp.push_back(1);
        fork
            req_issue(0, rnd(), rnd());
            req_issue(1, rnd(), rnd());
        join
        settle(14);
        chk("post_rst_grants_used", W'(gexp.size()), W'(0));
        chk("post_rst_exp0_drained", W'(exp0.size()), W'(0));
        chk("post_rst_exp1_drained", W'(exp1.size()), W'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish before 500000");
        $fatal(1, "bench did not terminate");
    end
endmodule
